// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2**ADDR_W x DATA_W general-register file, one write port, two
// registered read ports. GR0 reads as zero and is never written.
//
// Ports:
//   Clk     rising-edge clock
//   Clr     synchronous active-high clear of all registers and outputs
//   LE      write enable; RW selects the register, PW is the data
//   RE      read request; RA/RB are sampled on this edge
//   PA, PB  registered read data (held while RE=0)
//   RVALID  high for the cycle after an accepted RE
//
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write to a
// matching read port. Without it, a same-cycle read returns the stored value.

module regfile_2r1w #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              LE,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] PW,
    input  logic              RE,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic              RVALID
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NumRegs];
    logic [DATA_W-1:0] pa_d, pa_q;
    logic [DATA_W-1:0] pb_d, pb_q;
    logic              rvalid_d, rvalid_q;
    logic              wr_en;

    // Writes to GR0 are dropped so its storage stays at the cleared value.
    assign wr_en = LE && (RW != '0);

    always_comb begin
        pa_d     = pa_q;
        pb_d     = pb_q;
        rvalid_d = RE;
        if (RE) begin
            pa_d = mem_q[RA];
            pb_d = mem_q[RB];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (RW == RA)) pa_d = PW;
            if (wr_en && (RW == RB)) pb_d = PW;
`endif
            // GR0 is forced to zero regardless of stored contents.
            if (RA == '0) pa_d = '0;
            if (RB == '0) pb_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
            pa_q     <= '0;
            pb_q     <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (wr_en) mem_q[RW] <= PW;
            pa_q     <= pa_d;
            pb_q     <= pb_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign PA     = pa_q;
    assign PB     = pb_q;
    assign RVALID = rvalid_q;

endmodule
